// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: DM-priority with a starvation guard
// for IF, fixed-latency access sequencing and one-cycle acks.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] rdata,
   output logic        mem_sel,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic          en_q, en_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          if_ack_q, if_ack_d;
   logic          dm_ack_q, dm_ack_d;
   logic [3:0]    starve_q, starve_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          grant_dm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         starve_q <= '0;
         lat_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         if_ack_q <= if_ack_d;
         dm_ack_q <= dm_ack_d;
         starve_q <= starve_d;
         lat_q    <= lat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      en_d     = en_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      if_ack_d = 1'b0;
      dm_ack_d = 1'b0;
      starve_d = starve_q;
      lat_d    = lat_q;
      grant_dm = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dm_req || if_req) begin
               // IF is forced once DM has won STARVE_MAX times in a row
               grant_dm = dm_req && !(if_req && (starve_q == SMAX));
               sel_d    = grant_dm;
               en_d     = 1'b1;
               we_d     = grant_dm & dm_we;
               if (grant_dm && dm_we)
                  wdata_d = dm_wdata;
               lat_d    = LW'(MEM_LAT - 1);
               if (grant_dm && if_req)
                  starve_d = (starve_q == SMAX) ? starve_q
                                                : starve_q + 4'd1;
               else
                  starve_d = '0;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (lat_q != '0) begin
               lat_d = lat_q - LW'(1);
            end else begin
               if (!we_q)
                  rdata_d = mem_rdata;
               en_d     = 1'b0;
               we_d     = 1'b0;
               if_ack_d = !sel_q;
               dm_ack_d = sel_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign rdata     = rdata_q;
   assign mem_sel   = sel_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a
// behavioural memory and a cycle-level monitor built from the timing rules.
module tb_mem_port_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_wdata = '0;
   logic        dm_ack;
   logic [31:0] rdata;
   logic        mem_sel;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] if_word = '0;
   logic [31:0] dm_word = '0;
   logic [31:0] word;
   int          en_cnt;
   int          cyc_cnt = 0;

   int checks = 0;
   int fails  = 0;

   logic [32:0] if_q[$];
   logic [32:0] dm_q[$];
   bit          grant_log[$];

   mem_port_arbiter #(
      .MEM_LAT(MEM_LAT),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .if_req(if_req),
      .if_ack(if_ack),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_wdata(dm_wdata),
      .dm_ack(dm_ack),
      .rdata(rdata),
      .mem_sel(mem_sel),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // memory: read data valid only in the last cycle of the enable window
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_cnt <= 0;
      else        en_cnt <= mem_en ? en_cnt + 1 : 0;
   end

   always_comb begin
      word      = mem_sel ? dm_word : if_word;
      mem_rdata = (mem_en && en_cnt == MEM_LAT - 1) ? word : ~word;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      fails++;
      $display("FAIL %s actual=none required=event t=%0t", nm, $time);
   endtask

   // monitor: expected port behaviour from the arbitration and timing rules
   bit          busy;
   bit          in_acc, in_done;
   bit          e_sel, e_we, g;
   int          mcyc;
   int          scnt;
   logic [31:0] e_wdata, e_rdata;
   logic [32:0] ent;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 0; mcyc = 0; scnt = 0;
         e_sel = 0; e_we = 0; e_wdata = '0; e_rdata = '0;
         if_q.delete();
         dm_q.delete();
         chk("rst_ctrl", 64'({mem_en, mem_we, mem_sel, if_ack, dm_ack}),
             64'd0);
         chk("rst_data", {mem_wdata, rdata}, 64'd0);
      end else begin
         in_acc = 0;
         in_done = 0;
         if (busy) begin
            mcyc++;
            in_acc  = (mcyc <= MEM_LAT);
            in_done = (mcyc == MEM_LAT + 1);
         end
         if (in_done) begin
            if (!e_sel) begin
               if (if_q.size() == 0) miss("if_q_entry");
               else begin
                  ent = if_q.pop_front();
                  e_rdata = ent[31:0];
               end
            end else begin
               if (dm_q.size() == 0) miss("dm_q_entry");
               else begin
                  ent = dm_q.pop_front();
                  if (!ent[32]) e_rdata = ent[31:0];
                  else chk("dm_wr_data", 64'(mem_wdata), 64'(ent[31:0]));
               end
            end
         end
         chk("ctrl", 64'({mem_en, mem_we, mem_sel, if_ack, dm_ack}),
             64'({in_acc, in_acc & e_we, e_sel,
                  in_done & !e_sel, in_done & e_sel}));
         chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
         chk("rdata", 64'(rdata), 64'(e_rdata));
         if (in_done) begin
            busy = 0;
         end else if (!busy && (if_req || dm_req)) begin
            g = dm_req && !(if_req && scnt == STARVE_MAX);
            if (g && if_req) scnt = (scnt < STARVE_MAX) ? scnt + 1 : scnt;
            else             scnt = 0;
            e_sel = g;
            e_we  = g & dm_we;
            if (g && dm_we) e_wdata = dm_wdata;
            busy = 1;
            mcyc = 0;
            grant_log.push_back(g);
         end
      end
   end

   task automatic wait_ack(input bit dm, output bit ok);
      ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (dm ? dm_ack : if_ack) begin
            ok = 1;
            return;
         end
      end
      miss(dm ? "dm_ack_timeout" : "if_ack_timeout");
   endtask

   task automatic if_read(input logic [31:0] w);
      bit ok;
      int c0;
      if_word = w;
      if_q.push_back({1'b0, w});
      if_req = 1'b1;
      c0 = cyc_cnt;
      wait_ack(0, ok);
      if (ok) begin
         chk("if_lat", 64'(cyc_cnt - c0), 64'(MEM_LAT + 1));
         chk("if_rdata", 64'(rdata), 64'(w));
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic dm_op(input bit we, input logic [31:0] w);
      bit ok;
      dm_we = we;
      if (we) dm_wdata = w;
      else    dm_word = w;
      dm_q.push_back({we, w});
      dm_req = 1'b1;
      wait_ack(1, ok);
      @(posedge clk); #1;
      dm_req = 1'b0;
   endtask

   task automatic rand_if(input int n);
      bit ok;
      int gap;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            if_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         if_word = $urandom;
         if_q.push_back({1'b0, if_word});
         if_req = 1'b1;
         wait_ack(0, ok);
         @(posedge clk); #1;
      end
      if_req = 1'b0;
   endtask

   task automatic rand_dm(input int n);
      bit ok;
      int gap;
      logic [31:0] w;
      bit we;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            dm_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         w  = $urandom;
         we = 1'($urandom_range(0, 1));
         dm_we = we;
         if (we) dm_wdata = w;
         else    dm_word = w;
         dm_q.push_back({we, w});
         dm_req = 1'b1;
         wait_ack(1, ok);
         @(posedge clk); #1;
      end
      dm_req = 1'b0;
   endtask

   bit exp_g[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

   initial begin
      bit ok;
      int t_dm, t_if, n;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      if_read(32'h2008_0005);
      dm_op(1'b1, 32'hDEAD_BEEF);
      chk("wr_keeps_rdata", 64'(rdata), 64'h2008_0005);

      // simultaneous requests: DM first, IF one transaction later
      if_word = 32'hCAFE_0001;
      if_q.push_back({1'b0, if_word});
      dm_we = 1'b0;
      dm_word = 32'h0000_1234;
      dm_q.push_back({1'b0, dm_word});
      if_req = 1'b1;
      dm_req = 1'b1;
      wait_ack(1, ok);
      t_dm = cyc_cnt;
      if (ok) chk("both_dm_rdata", 64'(rdata), 64'h1234);
      @(posedge clk); #1;
      dm_req = 1'b0;
      wait_ack(0, ok);
      t_if = cyc_cnt;
      if (ok) chk("both_ack_gap", 64'(t_if - t_dm), 64'd4);
      @(posedge clk); #1;
      if_req = 1'b0;

      // both held: starvation guard pattern
      grant_log.delete();
      if_word = 32'h0BAD_F00D;
      dm_word = 32'h0000_5678;
      dm_we = 1'b0;
      if_q.push_back({1'b0, if_word});
      dm_q.push_back({1'b0, dm_word});
      if_req = 1'b1;
      dm_req = 1'b1;
      n = 0;
      for (int k = 0; k < 200 && n < 8; k++) begin
         @(posedge clk); #1;
         if (if_ack || dm_ack) begin
            n++;
            if (n < 8) begin
               if (if_ack) if_q.push_back({1'b0, if_word});
               else        dm_q.push_back({1'b0, dm_word});
            end
         end
      end
      if (n < 8) miss("starve_acks");
      @(posedge clk); #1;
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      if_q.delete();
      dm_q.delete();
      chk("starve_len", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         chk("starve_grant", 64'(grant_log[i]), 64'(exp_g[i]));

      // DM drops its request mid-access
      dm_we = 1'b0;
      dm_word = 32'h7777_0003;
      dm_q.push_back({1'b0, dm_word});
      dm_req = 1'b1;
      @(posedge clk); #1;
      dm_req = 1'b0;
      n = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (dm_ack) n++;
      end
      chk("drop_acks", 64'(n), 64'd1);

      // reset during ACCESS
      if_word = 32'h1111_2222;
      if_q.push_back({1'b0, if_word});
      if_req = 1'b1;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clk); #1;
         if (mem_en) ok = 1;
      end
      if (!ok) miss("rst_mem_en");
      #2 rst_n = 1'b0;
      #1 chk("rst_en_now", 64'(mem_en), 64'd0);
      if_req = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_noack", 64'({if_ack, dm_ack}), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      if_read(32'h5A5A_0001);

      fork
         rand_if(30);
         rand_dm(30);
      join
      repeat (6) begin @(posedge clk); #1; end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data memory (DM) requesters.
- Drives the select of the 32-bit address mux that sits in front of the memory: mem_sel=0 routes if_addr, mem_sel=1 routes dm_addr.
- Sequences each access over a fixed memory latency and returns read data with a one-cycle ack.
- Fixed DM priority, with a starvation guard that guarantees IF progress.

Parameters:
- MEM_LAT, 2, memory access cycles (mem_en window length); legal range >= 1.
- STARVE_MAX, 3, consecutive DM grants allowed while IF is pending before IF is forced; legal range >= 1, <= 15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF request; held with if_addr stable until if_ack.
- if_ack  out  1  one-cycle pulse; rdata valid.
- dm_req  in  1  DM request; held with dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_wdata  in  32  write data.
- dm_ack  out  1  one-cycle pulse; rdata valid for reads.
- rdata  out  32  read data returned to the granted requester.
- mem_sel  out  1  address mux select (0=IF, 1=DM).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the last cycle of the mem_en window.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async):
  - state=IDLE; if_ack=dm_ack=mem_en=mem_we=0; mem_sel=0; mem_wdata=0; rdata=0.
  - starve_cnt=0; lat_cnt=0.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, no request: stay in IDLE; outputs hold with mem_en=0.
- IDLE, request pending:
  - Grant DM if dm_req and NOT (if_req and starve_cnt==STARVE_MAX). Otherwise grant IF if if_req.
  - At the edge, register: mem_sel<=grant; mem_en<=1; mem_we<=grant&dm_we; mem_wdata<=dm_wdata if DM write, else unchanged; lat_cnt<=MEM_LAT-1. Go to ACCESS.
- Starvation counter:
  - At a DM grant with if_req=1: starve_cnt<=starve_cnt+1, saturating at STARVE_MAX.
  - At a DM grant with if_req=0, or at any IF grant: starve_cnt<=0.
- ACCESS:
  - mem_sel, mem_en, mem_we and mem_wdata are held constant.
  - If lat_cnt!=0, lat_cnt decrements.
  - If lat_cnt==0:
    - rdata<=mem_rdata for a read (an IF grant, or a DM grant with dm_we=0); rdata is unchanged for a write.
    - mem_en<=0; mem_we<=0.
    - Assert the ack of the granted port for the next cycle; go to DONE.
  - mem_en is high for exactly MEM_LAT cycles.
- DONE: the ack is high for exactly 1 cycle; mem_sel holds; go to IDLE.
- Latency:
  - A request seen in IDLE at cycle 0 gets mem_en in cycles 1..MEM_LAT and ack in cycle MEM_LAT+1.
  - Back-to-back transaction throughput is MEM_LAT+2 cycles per transaction.
- Requester rule: after seeing ack, the requester drops req (or presents a new request) in the following cycle, which is IDLE. There is no double grant.
- Boundary conditions:
  - req deasserted mid-transaction: ignored; the transaction completes and the ack still pulses.
  - Both requests in the same IDLE cycle: DM wins unless the starvation guard fires.
  - rst_n asserted mid-ACCESS or mid-DONE: the transaction is abandoned and no ack is issued. After release, the block starts from IDLE.
  - MEM_LAT=1: ACCESS lasts exactly 1 cycle.
  - if_ack and dm_ack are never high together.
  - mem_sel changes only at a grant edge.

Test Plan:
- Reset, then single IF read at addr 0x0040_0000 (MEM_LAT=2, memory returns 0x2008_0005) -> mem_sel=0, mem_en high cycles 1–2, if_ack in cycle 3, rdata=0x2008_0005.
- DM write of 0xDEAD_BEEF -> mem_sel=1, mem_we=1 for 2 cycles, mem_wdata=0xDEAD_BEEF, dm_ack in cycle 3, rdata unchanged.
- if_req and dm_req asserted together (DM read returns 0x1234) -> DM served first (dm_ack, rdata=0x1234); IF served next, with if_ack 4 cycles after dm_ack.
- Continuous DM requests with if_req held (STARVE_MAX=3) -> grants are DM, DM, DM, IF, DM…; starve_cnt goes 1, 2, 3, then 0.
- rst_n pulsed low during ACCESS -> mem_en=0 immediately and no ack. A fresh IF request after release completes normally in MEM_LAT+1 cycles.
- dm_req dropped during ACCESS -> dm_ack still pulses once; no new grant follows.
